axi2apb_ctrl_fsm: RTL and testbench
===================================

Name: axi2apb_ctrl_fsm

Overview:
APB master sequencer that sits directly upstream of the APB slave mux.
- Accepts one command at a time from the AXI-side command/response interface.
- Runs the APB SETUP/ACCESS phases and drives ctrl_psel and ctrl_addr_mux into the mux.
- Samples ctrl_pready, ctrl_pslverr and ctrl_prdata coming back from the mux.
- Adds a per-transfer timeout so a hung slave cannot stall the bridge.

Parameters:
SLV_SEL_LSB, 12, lowest address bit of the 4-bit slave index (ctrl_addr_mux = addr[SLV_SEL_LSB+3:SLV_SEL_LSB])
TIMEOUT_CYCLES, 1024, consecutive ACCESS cycles with ctrl_pready low before abort; 0 disables the timeout
CNT_W, 16, timeout counter width; TIMEOUT_CYCLES must be < 2**CNT_W

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  32  byte address
cmd_wdata  in  32  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_rdata  out  32  read data (0 for writes and errors)
rsp_err  out  1  slave error or timeout
paddr  out  32  APB address
pwrite  out  1  APB direction
pwdata  out  32  APB write data
penable  out  1  APB enable
ctrl_psel  out  1  APB select to mux
ctrl_addr_mux  out  4  slave index to mux
ctrl_pready  in  1  from mux
ctrl_pslverr  in  1  from mux
ctrl_prdata  in  32  from mux
timeout_o  out  1  one-cycle pulse when a transfer is aborted by timeout

Behaviour:
- Reset (synchronous, highest priority, any state): state=IDLE, cmd_ready=0, and 0 on paddr, pwrite, pwdata, penable, ctrl_psel, ctrl_addr_mux, rsp_valid, rsp_rdata, rsp_err, timeout_o; counter=0. Reset mid-transfer drops ctrl_psel/penable at the same edge; no response is produced for the aborted command.
- States: IDLE, SETUP, ACCESS, RESP (enum).
- IDLE: cmd_ready=1 (combinational from state). On cmd_valid:
  - register addr, write flag, wdata; ctrl_addr_mux=cmd_addr[SLV_SEL_LSB+3:SLV_SEL_LSB];
  - go to SETUP.
- SETUP: ctrl_psel=1, penable=0, cmd_ready=0; unconditionally go to ACCESS after one cycle.
- ACCESS: ctrl_psel=1, penable=1.
  - ctrl_pready=1: capture rsp_err=ctrl_pslverr; capture rsp_rdata=ctrl_prdata if read and no error, else 0; go to RESP; ctrl_psel/penable low next cycle.
  - ctrl_pready=0: counter increments.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 while ctrl_pready=0: abort, rsp_err=1, rsp_rdata=0, timeout_o pulses for one cycle, go to RESP.
  - ctrl_pready wins if it is high in the same cycle the timeout would fire.
- RESP: rsp_valid=1, outputs held stable until rsp_ready. On handshake go to IDLE; rsp_valid drops next cycle.
- Counter clears on entry to SETUP; it never wraps (saturating compare).
- Mux decode errors (index >= slave count) surface as pready=1, pslverr=1 and are reported as rsp_err=1 in the normal way.
- paddr/pwrite/pwdata are stable from SETUP through the end of ACCESS. They hold their last value in IDLE/RESP, with ctrl_psel low.
- Minimum latency: cmd handshake at cycle 0, SETUP at 1, ACCESS at 2 (pready=1), rsp_valid at 3; back-to-back command accepted at cycle 4 if rsp_ready=1 at 3.
- Only one outstanding command; no pipelining.

Decomposition:
- Shared package axi2apb_pkg holds:
  - apb_state_e enum (IDLE/SETUP/ACCESS/RESP);
  - APB_ADDR_W=32, APB_DATA_W=32, SLV_IDX_W=4.
- Sub-module axi2apb_timeout_cnt: clear/enable/limit inputs, expired output.

Test Plan:
- Read, slave 2 (cmd_addr=32'h0000_2010), pready=1 on the first ACCESS cycle, prdata=32'hDEADBEEF -> ctrl_addr_mux=2, psel high 2 cycles, penable 1 cycle, rsp_valid at cycle 3 with rdata=32'hDEADBEEF, err=0.
- Write with 3 pready-low wait states, pslverr=1 at completion -> penable high 4 cycles, pwdata stable throughout, rsp_err=1, rsp_rdata=0.
- TIMEOUT_CYCLES=8, pready held 0 -> abort after 8 ACCESS cycles, timeout_o single pulse, rsp_err=1, psel low the next cycle.
- rsp_ready held low 5 cycles in RESP -> rsp_valid/rdata/err stable, cmd_ready=0, no APB activity; next cmd accepted the cycle after the handshake.
- reset asserted during ACCESS -> psel/penable/rsp_valid 0 after the edge, state IDLE, cmd_ready=1 the cycle after reset deasserts.
- Index 12 (decode error: mux returns pready=1, pslverr=1) -> rsp_err=1, rsp_rdata=0, no timeout.

Source files
------------

// File: rtl/axi2apb_pkg.sv
// Shared types, widths and small helpers for the AXI-to-APB control sequencer.
package axi2apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int SLV_IDX_W  = 4;

  // APB phase sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Extract the slave index that the downstream mux decodes.
  function automatic logic [SLV_IDX_W-1:0] slv_index(
    input logic [APB_ADDR_W-1:0] addr,
    input int                    lsb
  );
    logic [APB_ADDR_W-1:0] shifted;
    shifted = addr >> lsb;
    return shifted[SLV_IDX_W-1:0];
  endfunction

  // Read data returned to the AXI side: only a successful read carries data.
  function automatic logic [APB_DATA_W-1:0] rsp_data_sel(
    input logic                  is_write,
    input logic                  slverr,
    input logic [APB_DATA_W-1:0] prdata
  );
    logic [APB_DATA_W-1:0] res;
    if (!is_write && !slverr) begin
      res = prdata;
    end else begin
      res = {APB_DATA_W{1'b0}};
    end
    return res;
  endfunction

endpackage

// File: rtl/axi2apb_timeout_cnt.sv
// Saturating wait-state counter; flags expiry once it reaches limit-1.
// A limit of zero disables expiry entirely.
module axi2apb_timeout_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CNT_ZERO;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Greater-or-equal keeps the flag asserted even if the count saturates.
  assign expired = (limit != CNT_ZERO) && (cnt_q >= (limit - CNT_ONE));

endmodule

// File: rtl/axi2apb_ctrl_fsm.sv
// APB master sequencer: accepts one command, runs SETUP/ACCESS towards the
// slave mux, returns a response, and aborts transfers stuck in wait states.
module axi2apb_ctrl_fsm
  import axi2apb_pkg::*;
#(
  parameter int SLV_SEL_LSB    = 12,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_ADDR_W-1:0] cmd_addr,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic                  pwrite,
  output logic [APB_DATA_W-1:0] pwdata,
  output logic                  penable,
  output logic                  ctrl_psel,
  output logic [SLV_IDX_W-1:0]  ctrl_addr_mux,
  input  logic                  ctrl_pready,
  input  logic                  ctrl_pslverr,
  input  logic [APB_DATA_W-1:0] ctrl_prdata,
  output logic                  timeout_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  apb_state_e            state_q,     state_d;
  logic [APB_ADDR_W-1:0] paddr_q,     paddr_d;
  logic                  pwrite_q,    pwrite_d;
  logic [APB_DATA_W-1:0] pwdata_q,    pwdata_d;
  logic                  penable_q,   penable_d;
  logic                  psel_q,      psel_d;
  logic [SLV_IDX_W-1:0]  addr_mux_q,  addr_mux_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic                  timeout_q,   timeout_d;

  logic cnt_clear_s;
  logic cnt_enable_s;
  logic cnt_expired_s;

  axi2apb_timeout_cnt #(
    .CNT_W(CNT_W)
  ) u_timeout_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear_s),
    .enable (cnt_enable_s),
    .limit  (TIMEOUT_LIM),
    .expired(cnt_expired_s)
  );

  // Next-state and next-output computation for the APB phase sequencer.
  always_comb begin
    state_d      = state_q;
    paddr_d      = paddr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    penable_d    = penable_q;
    psel_d       = psel_q;
    addr_mux_d   = addr_mux_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    timeout_d    = 1'b0;
    cnt_clear_s  = 1'b0;
    cnt_enable_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d     = cmd_addr;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_wdata;
          addr_mux_d  = slv_index(cmd_addr, SLV_SEL_LSB);
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          cnt_clear_s = 1'b1;
          state_d     = SETUP;
        end else begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end

      SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        // A ready slave takes priority over a timeout firing in the same cycle.
        if (ctrl_pready) begin
          rsp_err_d   = ctrl_pslverr;
          rsp_rdata_d = rsp_data_sel(pwrite_q, ctrl_pslverr, ctrl_prdata);
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else if (cnt_expired_s) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = {APB_DATA_W{1'b0}};
          rsp_valid_d = 1'b1;
          timeout_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_enable_s = 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset has priority in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      paddr_q     <= {APB_ADDR_W{1'b0}};
      pwrite_q    <= 1'b0;
      pwdata_q    <= {APB_DATA_W{1'b0}};
      penable_q   <= 1'b0;
      psel_q      <= 1'b0;
      addr_mux_q  <= {SLV_IDX_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {APB_DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      penable_q   <= penable_d;
      psel_q      <= psel_d;
      addr_mux_q  <= addr_mux_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      timeout_q   <= timeout_d;
    end
  end

  // Ready is held low while reset is asserted even though the state is IDLE.
  assign cmd_ready     = (state_q == IDLE) && !reset;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign paddr         = paddr_q;
  assign pwrite        = pwrite_q;
  assign pwdata        = pwdata_q;
  assign penable       = penable_q;
  assign ctrl_psel     = psel_q;
  assign ctrl_addr_mux = addr_mux_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_axi2apb_ctrl_fsm.sv
// Directed bench for axi2apb_ctrl_fsm: a vector table plus hand sequences.
module tb_axi2apb_ctrl_fsm;

  typedef struct packed {
    logic        rst;
    logic        cv;
    logic        cw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rr;
    logic        pr;
    logic        pe;
    logic [31:0] prdata;
  } in_t;

  typedef struct packed {
    logic        crdy;
    logic        psel;
    logic        pen;
    logic [3:0]  mux;
    logic        rv;
    logic        err;
    logic        to;
    logic        pw;
    logic [31:0] rdata;
    logic [31:0] paddr;
    logic [31:0] pwdata;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata, paddr, pwdata, ctrl_prdata;
  logic        pwrite, penable, ctrl_psel, ctrl_pready, ctrl_pslverr, timeout_o;
  logic [3:0]  ctrl_addr_mux;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  localparam logic [31:0] A_R  = 32'h0000_2010, WD_R = 32'h1111_1111;
  localparam logic [31:0] A_W  = 32'h0000_5004, WD_W = 32'hA5A5_5A5A;
  localparam logic [31:0] A_T  = 32'h0000_3000, WD_T = 32'h2222_2222;
  localparam logic [31:0] A_D  = 32'h0000_C000, WD_D = 32'h3333_3333;

  axi2apb_ctrl_fsm #(
    .SLV_SEL_LSB(12),
    .TIMEOUT_CYCLES(8),
    .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .penable(penable),
    .ctrl_psel(ctrl_psel), .ctrl_addr_mux(ctrl_addr_mux),
    .ctrl_pready(ctrl_pready), .ctrl_pslverr(ctrl_pslverr), .ctrl_prdata(ctrl_prdata),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  function automatic in_t mk_in(logic rst, logic cv, logic cw, logic [31:0] addr, logic [31:0] wdata,
                                logic rr, logic pr, logic pe, logic [31:0] prdata);
    in_t v;
    v = '{rst, cv, cw, addr, wdata, rr, pr, pe, prdata};
    return v;
  endfunction

  function automatic out_t mk_out(logic crdy, logic psel, logic pen, logic [3:0] mux, logic rv,
                                  logic err, logic to, logic pw, logic [31:0] rdata,
                                  logic [31:0] pa, logic [31:0] pwd);
    out_t v;
    v = '{crdy, psel, pen, mux, rv, err, to, pw, rdata, pa, pwd};
    return v;
  endfunction

  function automatic out_t sample();
    return mk_out(cmd_ready, ctrl_psel, penable, ctrl_addr_mux, rsp_valid, rsp_err,
                  timeout_o, pwrite, rsp_rdata, paddr, pwdata);
  endfunction

  task automatic drive(in_t v);
    reset        = v.rst;
    cmd_valid    = v.cv;
    cmd_write    = v.cw;
    cmd_addr     = v.addr;
    cmd_wdata    = v.wdata;
    rsp_ready    = v.rr;
    ctrl_pready  = v.pr;
    ctrl_pslverr = v.pe;
    ctrl_prdata  = v.prdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response payload is only meaningful while rsp_valid is expected high,
  // unless the comparison is a reset check where everything must be zero.
  task automatic check(string name, out_t act, out_t exp, bit full);
    out_t a, e;
    a = act;
    e = exp;
    if (!full && !e.rv) begin
      a.rdata = 32'h0; a.err = 1'b0;
      e.rdata = 32'h0; e.err = 1'b0;
    end
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got crdy=%b psel=%b pen=%b mux=%h rv=%b err=%b to=%b pw=%b rdata=%h paddr=%h pwdata=%h ; want crdy=%b psel=%b pen=%b mux=%h rv=%b err=%b to=%b pw=%b rdata=%h paddr=%h pwdata=%h",
               name, a.crdy, a.psel, a.pen, a.mux, a.rv, a.err, a.to, a.pw, a.rdata, a.paddr, a.pwdata,
               e.crdy, e.psel, e.pen, e.mux, e.rv, e.err, e.to, e.pw, e.rdata, e.paddr, e.pwdata);
    end
  endtask

  task automatic add(in_t i, out_t o);
    tbl.push_back('{i, o});
  endtask

  initial begin
    drive(mk_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));

    // Reset state, then idle.
    add(mk_in(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0),
        mk_out(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0));
    add(mk_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0),
        mk_out(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0));

    // Read from slave 2, zero wait states.
    add(mk_in(1'b0, 1'b1, 1'b0, A_R, WD_R, 1'b0, 1'b0, 1'b0, 32'h0),
        mk_out(1'b0, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, A_R, WD_R));
    add(mk_in(1'b0, 1'b0, 1'b0, A_R, WD_R, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF),
        mk_out(1'b0, 1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, A_R, WD_R));
    add(mk_in(1'b0, 1'b0, 1'b0, A_R, WD_R, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF),
        mk_out(1'b0, 1'b0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, A_R, WD_R));
    add(mk_in(1'b0, 1'b0, 1'b0, A_R, WD_R, 1'b1, 1'b0, 1'b0, 32'h0),
        mk_out(1'b1, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, A_R, WD_R));

    // Write to slave 5, three wait states, slave error at completion.
    add(mk_in(1'b0, 1'b1, 1'b1, A_W, WD_W, 1'b0, 1'b0, 1'b0, 32'h0),
        mk_out(1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, A_W, WD_W));
    for (int k = 0; k < 4; k++)
      add(mk_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0),
          mk_out(1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, A_W, WD_W));
    add(mk_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1234_5678),
        mk_out(1'b0, 1'b0, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, A_W, WD_W));
    add(mk_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0),
        mk_out(1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, A_W, WD_W));

    // Read from slave 3 that never becomes ready: abort after 8 ACCESS cycles.
    add(mk_in(1'b0, 1'b1, 1'b0, A_T, WD_T, 1'b0, 1'b0, 1'b0, 32'h0),
        mk_out(1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, A_T, WD_T));
    for (int k = 0; k < 8; k++)
      add(mk_in(1'b0, 1'b0, 1'b0, A_T, WD_T, 1'b0, 1'b0, 1'b0, 32'hFFFF_0000),
          mk_out(1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, A_T, WD_T));
    add(mk_in(1'b0, 1'b0, 1'b0, A_T, WD_T, 1'b0, 1'b0, 1'b0, 32'hFFFF_0000),
        mk_out(1'b0, 1'b0, 1'b0, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, A_T, WD_T));
    // Response stalled five cycles while a new command waits.
    for (int k = 0; k < 5; k++)
      add(mk_in(1'b0, 1'b1, 1'b0, A_D, WD_D, 1'b0, 1'b1, 1'b0, 32'h0),
          mk_out(1'b0, 1'b0, 1'b0, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, A_T, WD_T));
    add(mk_in(1'b0, 1'b1, 1'b0, A_D, WD_D, 1'b1, 1'b1, 1'b0, 32'h0),
        mk_out(1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, A_T, WD_T));
    // Waiting command (index 12, decode error) accepted right after the handshake.
    add(mk_in(1'b0, 1'b1, 1'b0, A_D, WD_D, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF),
        mk_out(1'b0, 1'b1, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, A_D, WD_D));
    add(mk_in(1'b0, 1'b0, 1'b0, A_D, WD_D, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF),
        mk_out(1'b0, 1'b1, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, A_D, WD_D));
    add(mk_in(1'b0, 1'b0, 1'b0, A_D, WD_D, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF),
        mk_out(1'b0, 1'b0, 1'b0, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, A_D, WD_D));
    add(mk_in(1'b0, 1'b0, 1'b0, A_D, WD_D, 1'b1, 1'b0, 1'b0, 32'h0),
        mk_out(1'b1, 1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, A_D, WD_D));

    foreach (tbl[n]) begin
      drive(tbl[n].i);
      step();
      check($sformatf("vec%0d", n), sample(), tbl[n].o, tbl[n].i.rst);
    end

    // Back-to-back reads with rsp_ready held high: second command at cycle 4.
    drive(mk_in(1'b0, 1'b1, 1'b0, 32'h0000_7008, 32'h0, 1'b1, 1'b1, 1'b0, 32'hCAFE_0001));
    step();
    check("b2b_setup", sample(),
          mk_out(1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_7008, 32'h0), 1'b0);
    cmd_addr = 32'h0000_9000;
    step();
    check("b2b_access", sample(),
          mk_out(1'b0, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_7008, 32'h0), 1'b0);
    step();
    check("b2b_rsp", sample(),
          mk_out(1'b0, 1'b0, 1'b0, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, 32'h0000_7008, 32'h0), 1'b0);
    step();
    check("b2b_idle", sample(),
          mk_out(1'b1, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_7008, 32'h0), 1'b0);
    step();
    cmd_valid = 1'b0;
    check("b2b_setup2", sample(),
          mk_out(1'b0, 1'b1, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_9000, 32'h0), 1'b0);
    // Bounded wait for the second response.
    begin
      int waited;
      waited = 0;
      while (!rsp_valid && waited < 20) begin
        step();
        waited++;
      end
      n_vec++;
      if (!rsp_valid || waited != 2) begin
        n_err++;
        $display("FAIL b2b_rsp2_latency: got rsp_valid=%b after %0d cycles, want 1 after 2", rsp_valid, waited);
      end
    end
    check("b2b_rsp2", sample(),
          mk_out(1'b0, 1'b0, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, 32'h0000_9000, 32'h0), 1'b0);
    step();

    // Reset in the middle of ACCESS: everything drops, no response follows.
    drive(mk_in(1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 32'h0));
    step();
    cmd_valid = 1'b0;
    step();
    check("rst_pre", sample(),
          mk_out(1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_1000, 32'h4444_4444), 1'b0);
    reset = 1'b1;
    step();
    check("rst_mid_access", sample(),
          mk_out(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0), 1'b1);
    reset = 1'b0;
    ctrl_pready = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("rst_after%0d", k), sample(),
            mk_out(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
